// File: rtl/upg_pkg.sv
// Shared types and constants for the UART frame loader.
// Optional build macro: UPG_CHECKSUM_EN (enables the trailing XOR checksum byte).
package upg_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
    CHK    = 3'd4,
    DONE   = 3'd5
  } state_t;

  localparam logic [7:0] CMD_INSTR = 8'h49;
  localparam logic [7:0] CMD_DATA  = 8'h44;

  localparam logic TARGET_INSTR = 1'b0;
  localparam logic TARGET_DATA  = 1'b1;

  function automatic logic cmd_valid(input logic [7:0] b);
    return (b == CMD_INSTR) || (b == CMD_DATA);
  endfunction

endpackage

// File: rtl/upg_frame_loader_if.sv
// Byte-stream input and memory write port of the frame loader.
// slave = loader side, master = byte source / memory side.
interface upg_frame_loader_if #(
  parameter int unsigned ADDR_W = 14
);
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          upg_wen_o;
  logic [ADDR_W:0] upg_adr_o;
  logic [31:0]   upg_dat_o;
  logic          upg_done_o;
  logic          upg_err_o;
  logic          busy_o;

  modport master (
    output rx_data, rx_valid,
    input  upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o, busy_o
  );

  modport slave (
    input  rx_data, rx_valid,
    output upg_wen_o, upg_adr_o, upg_dat_o, upg_done_o, upg_err_o, busy_o
  );
endinterface

// File: rtl/upg_word_packer.sv
// Little-endian byte-to-word packer: four accepted bytes produce one
// registered word plus a one-cycle word_valid pulse on the following cycle.
module upg_word_packer (
  input  logic        clock,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_byte,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  cnt;
  logic [23:0] sr;

  // next accepted byte completes the current word
  assign last_byte = (cnt == 2'd3);

  // shift bytes in from the top; publish the full word on the 4th byte
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
      word       <= '0;
    end else if (clear) begin
      cnt        <= '0;
      sr         <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (in_valid) begin
        cnt <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          word       <= {in_byte, sr};
          word_valid <= 1'b1;
        end else begin
          sr <= {in_byte, sr[23:8]};
        end
      end
    end
  end

endmodule

// File: rtl/upg_frame_loader.sv
// Framed UART download parser: CMD, LEN_LO, LEN_HI, LEN little-endian words,
// driving the instruction/data memory write port and done/err status.
// Optional build macro: UPG_CHECKSUM_EN adds a trailing XOR checksum byte.
module upg_frame_loader
  import upg_pkg::*;
#(
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
  input  logic                clock,
  input  logic                reset,
  upg_frame_loader_if.slave   bus
);

  localparam int unsigned TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t              state;
  logic                target;
  logic [7:0]          len_lo;
  logic [15:0]         len_m1;
  logic [ADDR_W-1:0]   addr;
  logic [ADDR_W:0]     adr_r;
  logic [TO_W-1:0]     to_cnt;
  logic                done_r;
  logic                err_r;

  logic                pk_valid;
  logic                pk_clear;
  logic                pk_last;
  logic                pk_word_valid;
  logic [31:0]         pk_word;

  logic [15:0]         len_full;
  logic                timeout;
  logic                load;
  logic                last_word;

  assign len_full  = {bus.rx_data, len_lo};
  assign timeout   = (state != IDLE) && !bus.rx_valid &&
                     (to_cnt == TO_W'(TIMEOUT_CYC - 1));
  assign pk_valid  = bus.rx_valid && (state == DATA);
  assign pk_clear  = (state == LEN_HI) || timeout;
  assign load      = pk_valid && pk_last;
  assign last_word = (32'(addr) == 32'(len_m1));

  upg_word_packer u_packer (
    .clock      (clock),
    .reset      (reset),
    .clear      (pk_clear),
    .in_valid   (pk_valid),
    .in_byte    (bus.rx_data),
    .last_byte  (pk_last),
    .word_valid (pk_word_valid),
    .word       (pk_word)
  );

`ifdef UPG_CHECKSUM_EN
  logic [7:0] xsum;

  // running XOR of the data bytes of the current frame
  always_ff @(posedge clock) begin
    if (reset)               xsum <= '0;
    else if (state == LEN_HI) xsum <= '0;
    else if (pk_valid)       xsum <= xsum ^ bus.rx_data;
  end
`endif

  // inter-byte idle counter, only meaningful inside a frame
  always_ff @(posedge clock) begin
    if (reset || bus.rx_valid || (state == IDLE) || timeout) to_cnt <= '0;
    else                                                    to_cnt <= to_cnt + 1'b1;
  end

  // frame parser FSM, address generation and sticky status
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      target <= TARGET_INSTR;
      len_lo <= '0;
      len_m1 <= '0;
      addr   <= '0;
      adr_r  <= '0;
      done_r <= 1'b0;
      err_r  <= 1'b0;
    end else if (timeout) begin
      err_r <= 1'b1;
      state <= IDLE;
    end else begin
      case (state)
        // DONE shares the IDLE byte handling so a CMD arriving in the
        // DONE cycle is not dropped; its later assignments take priority.
        IDLE, DONE: begin
          if (state == DONE) begin
            done_r <= 1'b1;
            state  <= IDLE;
          end
          if (bus.rx_valid) begin
            if (cmd_valid(bus.rx_data)) begin
              target <= (bus.rx_data == CMD_DATA) ? TARGET_DATA : TARGET_INSTR;
              done_r <= 1'b0;
              err_r  <= 1'b0;
              state  <= LEN_LO;
            end else begin
              err_r <= 1'b1;
            end
          end
        end
        LEN_LO: begin
          if (bus.rx_valid) begin
            len_lo <= bus.rx_data;
            state  <= LEN_HI;
          end
        end
        LEN_HI: begin
          if (bus.rx_valid) begin
            if (len_full == 16'd0) begin
              state <= DONE;
            end else if (32'(len_full) > (32'd1 << ADDR_W)) begin
              err_r <= 1'b1;
              state <= IDLE;
            end else begin
              len_m1 <= len_full - 16'd1;
              addr   <= '0;
              state  <= DATA;
            end
          end
        end
        DATA: begin
          if (load) begin
            adr_r <= {target, addr};
            addr  <= addr + 1'b1;
            if (last_word) begin
`ifdef UPG_CHECKSUM_EN
              state <= CHK;
`else
              state <= DONE;
`endif
            end
          end
        end
`ifdef UPG_CHECKSUM_EN
        CHK: begin
          if (bus.rx_valid) begin
            if (bus.rx_data == xsum) begin
              state <= DONE;
            end else begin
              err_r <= 1'b1;
              state <= IDLE;
            end
          end
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.upg_wen_o  = pk_word_valid;
  assign bus.upg_dat_o  = pk_word;
  assign bus.upg_adr_o  = adr_r;
  assign bus.upg_done_o = done_r;
  assign bus.upg_err_o  = err_r;
  assign bus.busy_o     = (state != IDLE);

endmodule
